// File: rtl/ghostbus_arb.sv
// Two-requester arbiter driving a single ghostbus master port (write or read with fixed read latency).
// Latency: write ack 2 cycles after req is sampled; read ack 2+RD_LAT cycles after req is sampled.
// Backpressure: requesters hold req level until ack; the loser waits with req held, no queueing.
module ghostbus_arb #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          gb_clk,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    input  logic [DW-1:0] gb_din,
    output logic          gb_we,
    output logic          gb_wstb,
    output logic          gb_rstb
);

    // Counter compare value; RD_LAT is limited to 1..15 so it fits the 4-bit counter.
    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;      // 1 = requester 1 was granted last
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          win1;

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            cnt_q    <= 4'd0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Next-state, arbitration and ghostbus strobe decode.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        win1     = 1'b0;
        gb_we    = 1'b0;
        gb_wstb  = 1'b0;
        gb_rstb  = 1'b0;
        ack0     = 1'b0;
        ack1     = 1'b0;

        case (state_q)
            IDLE: begin
                // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
                win1 = req1 & (~req0 | ~last_q);
                if (req0 | req1) begin
                    grant_d = win1 ? 2'b10 : 2'b01;
                    last_d  = win1;
                    we_d    = win1 ? we1 : we0;
                    addr_d  = win1 ? addr1 : addr0;
                    dout_d  = win1 ? wdata1 : wdata0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                gb_we   = we_q;
                gb_wstb = we_q;
                gb_rstb = ~we_q;
                if (we_q) begin
                    state_d = ACK;
                end else begin
                    // First cycle after the read strobe is count 1.
                    cnt_d   = 4'd1;
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                if (cnt_q == RD_LAT_C) begin
                    if (grant_q[1]) begin
                        rdata1_d = gb_din;
                    end else begin
                        rdata0_d = gb_din;
                    end
                    cnt_d   = 4'd0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ACK: begin
                ack0    = grant_q[0];
                ack1    = grant_q[1];
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign gb_clk  = clk;
    assign gb_addr = addr_q;
    assign gb_dout = dout_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_ghostbus_arb.sv
// Bench for ghostbus_arb: table of single transactions, then contention, back-to-back and reset-abort sequences.
// Expected transactions are queued when driven and checked against strobes and acks as they appear.
// Read data is supplied on gb_din only in the exact cycle it must be sampled.
module tb_ghostbus_arb;

    localparam int AW     = 24;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [1:0]    grant;
    logic          busy, gb_clk;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_dout;
    logic [DW-1:0] gb_din = '0;
    logic          gb_we, gb_wstb, gb_rstb;

    ghostbus_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .grant(grant), .busy(busy), .gb_clk(gb_clk),
        .gb_addr(gb_addr), .gb_dout(gb_dout), .gb_din(gb_din),
        .gb_we(gb_we), .gb_wstb(gb_wstb), .gb_rstb(gb_rstb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;      // write data, or read data to supply and expect
        int            issue_cyc; // cycle of the strobe, -1 = not checked
        int            ack_cyc;
    } exp_t;

    typedef struct {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    exp_t          sb[$];
    vec_t          tbl[8];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [DW-1:0] m_rd0, m_rd1;
    int            rd_cnt   = 0;
    logic [DW-1:0] rd_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ack"}, {62'd0, ack1, ack0}, 0);
        chk({tag, "_rdata0"}, 64'(rdata0), 0);
        chk({tag, "_rdata1"}, 64'(rdata1), 0);
        chk({tag, "_grant"}, 64'(grant), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_gb_addr"}, 64'(gb_addr), 0);
        chk({tag, "_gb_dout"}, 64'(gb_dout), 0);
        chk({tag, "_strobes"}, {61'd0, gb_we, gb_wstb, gb_rstb}, 0);
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ack_timeout", 1, 0);
    endtask

    // Cycle counter: cyc equals the number of rising edges seen so far.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor/scoreboard plus gb_din responder.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            m_rd0  = '0;
            m_rd1  = '0;
            rd_cnt = 0;
        end else begin
            if (gb_wstb || gb_rstb) begin
                chk("strobe_excl", 64'(gb_wstb & gb_rstb), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = sb[0];
                    chk("gb_we", 64'(gb_we), 64'(e.we));
                    chk("gb_wstb", 64'(gb_wstb), 64'(e.we));
                    chk("gb_rstb", 64'(gb_rstb), 64'(!e.we));
                    chk("gb_addr", 64'(gb_addr), 64'(e.addr));
                    if (e.we) chk("gb_dout", 64'(gb_dout), 64'(e.data));
                    chk("grant", 64'(grant), e.id ? 2 : 1);
                    chk("busy_issue", 64'(busy), 1);
                    if (e.issue_cyc >= 0) chk("issue_cyc", 64'(cyc), 64'(e.issue_cyc));
                    if (!e.we) begin
                        rd_cnt = RD_LAT;
                        rd_val = e.data;
                    end
                end
            end
            if (ack0 || ack1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_id", {62'd0, ack1, ack0}, e.id ? 2 : 1);
                    chk("ack_addr_hold", 64'(gb_addr), 64'(e.addr));
                    if (!e.we) begin
                        if (e.id) m_rd1 = e.data;
                        else      m_rd0 = e.data;
                    end
                    chk("rdata0", 64'(rdata0), 64'(m_rd0));
                    chk("rdata1", 64'(rdata1), 64'(m_rd1));
                    if (e.issue_cyc >= 0) chk("ack_cyc", 64'(cyc), 64'(e.ack_cyc));
                end
            end
        end
        @(posedge clk);
        #1;
        if (rd_cnt != 0) begin
            rd_cnt--;
            gb_din = (rd_cnt == 0) ? rd_val : $urandom;
        end else begin
            gb_din = $urandom;
        end
    end

    // Single transaction from the table, starting in an IDLE cycle.
    task automatic run_txn(input vec_t v);
        exp_t e;
        bit   ok;
        int   k;
        @(negedge clk);
        k = cyc + 1;
        e.id = v.id; e.we = v.we; e.addr = v.addr;
        e.data = v.we ? v.wdata : v.din;
        e.issue_cyc = k;
        e.ack_cyc = v.we ? k + 1 : k + 1 + RD_LAT;
        chk("tbl_exp_rdata", 64'(v.din), 64'(v.exp_rdata));
        sb.push_back(e);
        if (v.id) begin
            req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
            addr0 = AW'($urandom); wdata0 = $urandom;
        end else begin
            req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
            addr1 = AW'($urandom); wdata1 = $urandom;
        end
        wait_ack(ok);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    function automatic exp_t mk(input logic id, input logic we, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input int ic, input int ac);
        exp_t e;
        e.id = id; e.we = we; e.addr = a; e.data = d; e.issue_cyc = ic; e.ack_cyc = ac;
        return e;
    endfunction

    initial begin
        bit ok;
        int k;
        tbl[0] = '{1'b0, 1'b1, 24'h000010, 32'hDEADBEEF, 32'h0,        32'h0};
        tbl[1] = '{1'b1, 1'b0, 24'h000020, 32'h0,        32'h12345678, 32'h12345678};
        tbl[2] = '{1'b0, 1'b0, 24'h000030, 32'h0,        32'hA5A55A5A, 32'hA5A55A5A};
        tbl[3] = '{1'b1, 1'b1, 24'h000040, 32'h0F0F0F0F, 32'h0,        32'h0};
        tbl[4] = '{1'b0, 1'b1, 24'hFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0};
        tbl[5] = '{1'b1, 1'b0, 24'hFFFFFF, 32'h0,        32'h00000000, 32'h00000000};
        tbl[6] = '{1'b0, 1'b0, 24'h000000, 32'h0,        32'h80000001, 32'h80000001};
        tbl[7] = '{1'b1, 1'b1, 24'h000000, 32'h00000000, 32'h0,        32'h0};

        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1 chk_reset("por");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(tbl[i]);

        // Contention from reset release: grants alternate 0,1,0,1.
        @(negedge clk);
        #1 rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 24'h000100; wdata0 = 32'h11111111;
        req1 = 1'b1; we1 = 1'b0; addr1 = 24'h000200; wdata1 = 32'h22222222;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        k = cyc + 1;
        sb.push_back(mk(1'b0, 1'b1, 24'h000100, 32'h11111111, k,      k + 1));
        sb.push_back(mk(1'b1, 1'b0, 24'h000200, 32'hCAFE0001, k + 3,  k + 4 + RD_LAT));
        sb.push_back(mk(1'b0, 1'b1, 24'h000100, 32'h11111111, k + 8,  k + 9));
        sb.push_back(mk(1'b1, 1'b0, 24'h000200, 32'hCAFE0002, k + 11, k + 12 + RD_LAT));
        for (int n = 0; n < 4; n++) wait_ack(ok);
        req0 = 1'b0;
        req1 = 1'b0;

        // Back-to-back writes with req0 held: one strobe every 3 cycles.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 24'h000123; wdata0 = 32'h00000ABC;
        k = cyc + 1;
        for (int n = 0; n < 4; n++)
            sb.push_back(mk(1'b0, 1'b1, 24'h000123, 32'h00000ABC, k + 3 * n, k + 3 * n + 1));
        for (int n = 0; n < 4; n++) wait_ack(ok);
        req0 = 1'b0;

        // Reset during RWAIT aborts the read; held req1 is reissued afterwards.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 24'h000300; wdata1 = 32'h33333333;
        k = cyc + 1;
        sb.push_back(mk(1'b1, 1'b0, 24'h000300, 32'h55AA55AA, k, k + 1 + RD_LAT));
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gb_rstb) begin
                ok = 1'b1;
                break;
            end
        end
        chk("abort_rstb_seen", 64'(ok), 1);
        @(negedge clk);
        chk("abort_in_rwait", 64'(busy & ~gb_rstb & ~ack1), 1);
        #1 rst_n = 1'b0;
        #1 chk_reset("abort");
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        k = cyc + 1;
        sb.push_back(mk(1'b1, 1'b0, 24'h000300, 32'h0BADF00D, k, k + 1 + RD_LAT));
        wait_ack(ok);
        req1 = 1'b0;

        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("sb_drain", 64'(sb.size()), 0);
        @(negedge clk);
        chk("idle_busy", 64'(busy), 0);
        chk("idle_grant", 64'(grant), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
